// File: rtl/instr_memory.sv
// Instruction memory with a byte-serial boot loader; the CPU stays in reset until the image is complete.
// Fetch data is combinational from the address; loader state and outputs are registered.
// o_loadReady is high only while loading; the loader may hold i_loadValid low between bytes.
module instr_memory #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic        i_clock,
    input  logic        i_resetn,
    input  logic [31:0] i_imemAddr,
    output logic [31:0] o_imemData,
    input  logic        i_loadValid,
    input  logic [7:0]  i_loadByte,
    input  logic        i_loadLast,
    output logic        o_loadReady,
    output logic        o_loadDone,
    output logic        o_loadError,
    output logic        o_cpuResetn
);
    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam int          PW   = AW + 1;
    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {LOAD, RUN, ERROR} state_t;

    state_t                 state;
    logic [1:0]             byte_idx;
    logic [PW-1:0]          wptr;
    logic [31:0]            asm_word;
    logic [DEPTH_WORDS-1:0] valid;
    logic [31:0]            mem [DEPTH_WORDS];

    logic        accept;
    logic        overflow;
    logic        wr_en;
    logic [31:0] wr_word;
    logic [31:0] off;
    logic        hit;

    // o_loadReady is a registered copy of (state == LOAD)
    assign accept   = i_loadValid && o_loadReady;
    assign overflow = (wptr == PW'(DEPTH_WORDS));
    assign wr_en    = accept && !overflow && ((byte_idx == 2'd3) || i_loadLast);

    // Bytes above the current index read as zero, which pads a short final word.
    always_comb begin
        wr_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(byte_idx))
                wr_word[8*k +: 8] = asm_word[8*k +: 8];
            else if (k == int'(byte_idx))
                wr_word[8*k +: 8] = i_loadByte;
        end
    end

    always_ff @(posedge i_clock or negedge i_resetn) begin
        if (!i_resetn) begin
            state       <= LOAD;
            byte_idx    <= '0;
            wptr        <= '0;
            asm_word    <= '0;
            valid       <= '0;
            o_loadReady <= 1'b1;
            o_loadDone  <= 1'b0;
            o_loadError <= 1'b0;
            o_cpuResetn <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (overflow) begin
                            state       <= ERROR;
                            o_loadReady <= 1'b0;
                            o_loadError <= 1'b1;
                        end else begin
                            asm_word[8*byte_idx +: 8] <= i_loadByte;
                            byte_idx                  <= byte_idx + 2'd1;
                            if (wr_en) begin
                                valid[wptr[AW-1:0]] <= 1'b1;
                                wptr                <= wptr + PW'(1);
                            end
                            if (i_loadLast) begin
                                state       <= RUN;
                                o_loadReady <= 1'b0;
                                o_loadDone  <= 1'b1;
                                o_cpuResetn <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Array is not reset; stale contents stay hidden behind the cleared valid bits.
    always_ff @(posedge i_clock) begin
        if (wr_en)
            mem[wptr[AW-1:0]] <= wr_word;
    end

    assign off = i_imemAddr - BASE_ADDR;
    assign hit = (state == RUN) && (i_imemAddr[1:0] == 2'b00) &&
                 (i_imemAddr >= BASE_ADDR) && ({1'b0, off} < SPAN) &&
                 valid[off[AW+1:2]];
    assign o_imemData = hit ? mem[off[AW+1:2]] : NOP_INSTR;
endmodule

// File: tb/tb_instr_memory.sv
// Scoreboard bench: stimulus queues expectations, a negedge monitor pops and compares.
// Instance 0 uses the default depth, instance 1 uses DEPTH_WORDS=4 for overflow cases.
module tb_instr_memory;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int K_DATA = 0, K_STAT = 1, K_RDY = 2;

    logic        clk = 1'b0;
    logic [1:0]  rstn = 2'b00;
    logic [1:0]  lv = 2'b00;
    logic [1:0]  ll = 2'b00;
    logic [1:0]  rdy, dn, er, cr;
    logic [7:0]  lb [2];
    logic [31:0] ad [2];
    logic [31:0] dat [2];

    typedef struct {
        int          d;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t        q [$];
    string       nq [$];
    logic        chk_req = 1'b0;
    int          checks = 0;
    int          errors = 0;
    exp_t        e;
    string       nm;
    logic [31:0] act;

    always #5 clk = ~clk;

    instr_memory u_big (
        .i_clock(clk), .i_resetn(rstn[0]), .i_imemAddr(ad[0]), .o_imemData(dat[0]),
        .i_loadValid(lv[0]), .i_loadByte(lb[0]), .i_loadLast(ll[0]),
        .o_loadReady(rdy[0]), .o_loadDone(dn[0]), .o_loadError(er[0]), .o_cpuResetn(cr[0])
    );

    instr_memory #(.DEPTH_WORDS(4)) u_small (
        .i_clock(clk), .i_resetn(rstn[1]), .i_imemAddr(ad[1]), .o_imemData(dat[1]),
        .i_loadValid(lv[1]), .i_loadByte(lb[1]), .i_loadLast(ll[1]),
        .o_loadReady(rdy[1]), .o_loadDone(dn[1]), .o_loadError(er[1]), .o_cpuResetn(cr[1])
    );

    // Monitor: status is packed {ready, done, error, cpuResetn}
    always @(negedge clk) begin
        if (chk_req) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL monitor: output presented with no expectation queued");
            end else begin
                e  = q.pop_front();
                nm = nq.pop_front();
                case (e.kind)
                    K_DATA:  act = dat[e.d];
                    K_STAT:  act = {28'd0, rdy[e.d], dn[e.d], er[e.d], cr[e.d]};
                    default: act = {31'd0, rdy[e.d]};
                endcase
                if (act !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %h expected %h", nm, act, e.exp);
                end
            end
        end
    end

    task automatic expect_cycle(input int d, input int kind, input logic [31:0] exp, input string name);
        exp_t x;
        x.d = d; x.kind = kind; x.exp = exp;
        q.push_back(x);
        nq.push_back(name);
        chk_req = 1'b1;
        @(posedge clk); #1;
        chk_req = 1'b0;
    endtask

    task automatic fetch(input int d, input logic [31:0] a, input logic [31:0] exp, input string name);
        ad[d] = a;
        expect_cycle(d, K_DATA, exp, name);
    endtask

    task automatic status(input int d, input logic [3:0] exp, input string name);
        expect_cycle(d, K_STAT, {28'd0, exp}, name);
    endtask

    task automatic do_reset(input int d);
        rstn[d] = 1'b0;
        @(posedge clk); #1;
        rstn[d] = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // The accepting cycle doubles as a check that ready was high within the budget.
    task automatic send(input int d, input logic [7:0] b, input logic last);
        lv[d] = 1'b1; lb[d] = b; ll[d] = last;
        for (int n = 0; n < 20; n++) begin
            if (rdy[d]) break;
            @(posedge clk); #1;
        end
        expect_cycle(d, K_RDY, 32'd1, "load_ready_at_accept");
        lv[d] = 1'b0; ll[d] = 1'b0;
    endtask

    initial begin
        logic [7:0] img1 [8];
        logic [7:0] img2 [6];
        img1 = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        img2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        lb[0] = '0; lb[1] = '0; ad[0] = '0; ad[1] = '0;
        idle(2);
        rstn = 2'b11;
        idle(1);

        // Two-word image
        do_reset(0);
        status(0, 4'b1000, "reset_status");
        fetch(0, 32'h0, NOP, "reset_fetch0");
        for (int i = 0; i < 7; i++) send(0, img1[i], 1'b0);
        fetch(0, 32'h0, NOP, "load_fetch0_hidden");
        status(0, 4'b1000, "load_cpu_held");
        send(0, img1[7], 1'b1);
        status(0, 4'b0101, "run_status");
        fetch(0, 32'h0, 32'h00A00513, "fetch_w0");
        fetch(0, 32'h4, 32'h00100593, "fetch_w1");
        fetch(0, 32'h8, NOP, "fetch_unwritten");
        fetch(0, 32'h2, NOP, "fetch_misaligned");
        fetch(0, 32'h400, NOP, "fetch_out_of_range");
        fetch(0, 32'h3FC, NOP, "fetch_last_unwritten");

        // Short final word is zero padded
        do_reset(0);
        status(0, 4'b1000, "reset2_status");
        for (int i = 0; i < 6; i++) send(0, img2[i], i == 5);
        status(0, 4'b0101, "pad_done");
        fetch(0, 32'h0, 32'h44332211, "pad_w0");
        fetch(0, 32'h4, 32'h00006655, "pad_w1");

        // Stalled partial load, reset, reload
        do_reset(0);
        send(0, 8'h01, 1'b0); idle(3);
        send(0, 8'h02, 1'b0); idle(2);
        send(0, 8'h03, 1'b0); idle(1);
        do_reset(0);
        status(0, 4'b1000, "midload_reset_status");
        send(0, 8'hAA, 1'b0);
        send(0, 8'hBB, 1'b0); idle(2);
        send(0, 8'hCC, 1'b0);
        send(0, 8'hDD, 1'b1);
        fetch(0, 32'h0, 32'hDDCCBBAA, "reload_w0");
        fetch(0, 32'h4, NOP, "reload_old_w1_hidden");

        // Small memory: overflow
        do_reset(1);
        for (int i = 0; i < 16; i++) send(1, 8'(i), 1'b0);
        status(1, 4'b1000, "small_full_still_loading");
        send(1, 8'hFF, 1'b1);
        status(1, 4'b0010, "small_overflow_error");
        fetch(1, 32'h0, NOP, "small_error_fetch");

        // Small memory: exact fill ends in RUN
        do_reset(1);
        for (int i = 0; i < 16; i++) send(1, 8'(8'h10 + i), i == 15);
        status(1, 4'b0101, "small_exact_run");
        fetch(1, 32'h0, 32'h13121110, "small_w0");
        fetch(1, 32'hC, 32'h1F1E1D1C, "small_w3");
        fetch(1, 32'h10, NOP, "small_out_of_range");

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
